// File: rtl/song_sequencer.sv
// Song sequencer: steps through an external synchronous note ROM, drives buzzer note,
// octave and one-hot LEDs, with play/pause, loop/stop, song select and articulation gap.
module song_sequencer #(
  parameter int unsigned       TICK_DIV   = 10000000,
  parameter int unsigned       SONG_LEN   = 56,
  parameter int unsigned       NUM_SONGS  = 6,
  parameter int unsigned       NOTE_W     = 4,
  parameter int unsigned       OCT_W      = 2,
  parameter int unsigned       DUR_W      = 4,
  parameter logic [NOTE_W-1:0] END_CODE   = 4'hF,
  parameter int unsigned       GAP_CYCLES = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [1:0]                       song_select,
  input  logic                             play_pause,
  input  logic                             loop_en,
  output logic [$clog2(NUM_SONGS+1)-1:0]   rom_song,
  output logic [$clog2(SONG_LEN)-1:0]      rom_pos,
  input  logic [NOTE_W+OCT_W+DUR_W-1:0]    rom_data,
  output logic [NOTE_W-1:0]                note_to_play,
  output logic [OCT_W-1:0]                 octave_auto,
  output logic [6:0]                       led_out,
  output logic [$clog2(NUM_SONGS+1)-1:0]   song_num,
  output logic                             playing,
  output logic                             song_done
);

  localparam int unsigned SONG_W = $clog2(NUM_SONGS+1);
  localparam int unsigned POS_W  = $clog2(SONG_LEN);
  localparam int unsigned TICK_W = $clog2(TICK_DIV);

  localparam logic [SONG_W-1:0] SONG_FIRST = SONG_W'(1);
  localparam logic [SONG_W-1:0] SONG_LAST  = SONG_W'(NUM_SONGS);
  localparam logic [POS_W-1:0]  POS_LAST   = POS_W'(SONG_LEN-1);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV-1);
  localparam logic [TICK_W-1:0] PLAY_LAST  = TICK_W'(TICK_DIV-1-GAP_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_PLAY, S_GAP, S_PAUSE} state_t;

  state_t              state, resume_state;
  logic [POS_W-1:0]    pos;
  logic [TICK_W-1:0]   tick;
  logic [DUR_W-1:0]    units;
  logic [NOTE_W-1:0]   cur_note;
  logic [OCT_W-1:0]    cur_oct;
  logic [1:0]          sel_q;
  logic                pp_q;

  logic [1:0]          sel_rise;
  logic                pp_rise;
  logic [NOTE_W-1:0]   rd_note;
  logic [OCT_W-1:0]    rd_oct;
  logic [DUR_W-1:0]    rd_dur;
  logic                wait_end, play_end, gap_end, advance, song_end;
  logic [SONG_W-1:0]   song_next, song_prev;

  function automatic logic [6:0] led_of(input logic [NOTE_W-1:0] n);
    if (n != '0 && 32'(n) <= 32'd7) return 7'd1 << (n - NOTE_W'(1));
    return '0;
  endfunction

  assign rom_song  = song_num;
  assign rom_pos   = pos;

  assign sel_rise  = song_select & ~sel_q;
  assign pp_rise   = play_pause & ~pp_q;

  assign rd_note   = rom_data[NOTE_W+OCT_W+DUR_W-1 -: NOTE_W];
  assign rd_oct    = rom_data[OCT_W+DUR_W-1 -: OCT_W];
  assign rd_dur    = rom_data[DUR_W-1:0];

  assign song_next = (song_num == SONG_LAST)  ? SONG_FIRST : song_num + SONG_W'(1);
  assign song_prev = (song_num == SONG_FIRST) ? SONG_LAST  : song_num - SONG_W'(1);

  // A skipped entry in the last slot wraps the position, which also ends the song
  assign wait_end  = (rd_note == END_CODE) || (rd_dur == '0 && pos == POS_LAST);
  assign play_end  = (state == S_PLAY) && (units == DUR_W'(1)) && (tick == PLAY_LAST);
  assign gap_end   = (state == S_GAP) && (tick == TICK_LAST);
  assign advance   = gap_end || (play_end && GAP_CYCLES == 0);
  assign song_end  = ((state == S_WAIT) && wait_end) || (advance && pos == POS_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      resume_state <= S_IDLE;
      song_num     <= SONG_FIRST;
      pos          <= '0;
      tick         <= '0;
      units        <= '0;
      cur_note     <= '0;
      cur_oct      <= '0;
      note_to_play <= '0;
      octave_auto  <= '0;
      led_out      <= '0;
      playing      <= 1'b0;
      song_done    <= 1'b0;
      sel_q        <= '0;
      pp_q         <= 1'b0;
    end else begin
      sel_q     <= song_select;
      pp_q      <= play_pause;
      song_done <= 1'b0;
      if (sel_rise != 2'b00) begin
        song_num     <= sel_rise[0] ? song_next : song_prev;
        pos          <= '0;
        tick         <= '0;
        units        <= '0;
        note_to_play <= '0;
        octave_auto  <= '0;
        led_out      <= '0;
        case (state)
          S_IDLE:  ;
          S_PAUSE: resume_state <= S_FETCH;
          default: state <= S_FETCH;
        endcase
      end else if (pp_rise && state inside {S_IDLE, S_PLAY, S_GAP, S_PAUSE}) begin
        case (state)
          S_IDLE: begin
            state   <= S_FETCH;
            playing <= 1'b1;
          end
          S_PAUSE: begin
            state   <= resume_state;
            playing <= 1'b1;
            if (resume_state == S_PLAY) begin
              note_to_play <= cur_note;
              octave_auto  <= cur_oct;
              led_out      <= led_of(cur_note);
            end
          end
          default: begin
            resume_state <= state;
            state        <= S_PAUSE;
            playing      <= 1'b0;
            note_to_play <= '0;
            octave_auto  <= '0;
            led_out      <= '0;
          end
        endcase
      end else begin
        case (state)
          S_FETCH: state <= S_WAIT;
          S_WAIT: begin
            if (!wait_end && rd_dur == '0) begin
              pos   <= pos + POS_W'(1);
              state <= S_FETCH;
            end else if (!wait_end) begin
              cur_note     <= rd_note;
              cur_oct      <= rd_oct;
              note_to_play <= rd_note;
              octave_auto  <= rd_oct;
              led_out      <= led_of(rd_note);
              units        <= rd_dur;
              tick         <= '0;
              state        <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (tick == TICK_LAST) begin
              tick  <= '0;
              units <= units - DUR_W'(1);
            end else begin
              tick <= tick + TICK_W'(1);
            end
            if (play_end && GAP_CYCLES != 0) begin
              state        <= S_GAP;
              note_to_play <= '0;
              octave_auto  <= '0;
              led_out      <= '0;
            end
          end
          // GAP keeps counting ticks from PLAY_LAST+1 up to TICK_LAST
          S_GAP:   tick <= tick + TICK_W'(1);
          default: ;
        endcase
        // End-of-song and position advance deliberately override the per-state updates above
        if (song_end) begin
          pos <= '0;
          if (loop_en) begin
            state <= S_FETCH;
          end else begin
            state        <= S_IDLE;
            playing      <= 1'b0;
            song_done    <= 1'b1;
            note_to_play <= '0;
            octave_auto  <= '0;
            led_out      <= '0;
          end
        end else if (advance) begin
          pos   <= pos + POS_W'(1);
          state <= S_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed scenarios plus random button activity, checked
// every cycle against a trace model built from the ROM contents.
module tb_song_sequencer;

  localparam int unsigned TD  = 4;
  localparam int unsigned GAP = 1;
  localparam int unsigned SL  = 8;
  localparam int unsigned NS  = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] song_select = 2'b00;
  logic       play_pause = 1'b0;
  logic       loop_en = 1'b0;
  logic [2:0] rom_song;
  logic [2:0] rom_pos;
  logic [9:0] rom_data;
  logic [3:0] note_to_play;
  logic [1:0] octave_auto;
  logic [6:0] led_out;
  logic [2:0] song_num;
  logic       playing;
  logic       song_done;

  song_sequencer #(
    .TICK_DIV(TD), .SONG_LEN(SL), .NUM_SONGS(NS), .NOTE_W(4), .OCT_W(2),
    .DUR_W(4), .END_CODE(4'hF), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset), .song_select(song_select), .play_pause(play_pause),
    .loop_en(loop_en), .rom_song(rom_song), .rom_pos(rom_pos), .rom_data(rom_data),
    .note_to_play(note_to_play), .octave_auto(octave_auto), .led_out(led_out),
    .song_num(song_num), .playing(playing), .song_done(song_done)
  );

  always #5 clk = ~clk;

  logic [9:0] rom [0:7][0:7];
  always_ff @(posedge clk) rom_data <= rom[rom_song][rom_pos];

  int unsigned total = 0;
  int unsigned bad = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: each play-through of a song is a flat list of cycles.
  typedef enum {PH_FETCH, PH_WAIT, PH_PLAY, PH_GAP} ph_t;
  typedef struct {
    ph_t         ph;
    int unsigned note;
    int unsigned oct;
    int unsigned pos;
  } slot_t;
  typedef enum {M_IDLE, M_RUN, M_PAUSE} mode_t;

  slot_t       trace[$];
  mode_t       m_mode;
  int unsigned m_idx, m_song;
  bit          m_done;
  logic [1:0]  m_sel_q;
  logic        m_pp_q;

  function automatic logic [9:0] ent(input int unsigned n, input int unsigned o, input int unsigned d);
    return {4'(n), 2'(o), 4'(d)};
  endfunction

  function automatic int unsigned exp_led(input int unsigned n);
    return (n >= 1 && n <= 7) ? (32'd1 << (n - 1)) : 32'd0;
  endfunction

  task automatic add_slot(input ph_t ph, input int unsigned n, input int unsigned o, input int unsigned p);
    slot_t s;
    s.ph = ph; s.note = n; s.oct = o; s.pos = p;
    trace.push_back(s);
  endtask

  task automatic build_trace(input int unsigned song);
    int unsigned p = 0;
    bit fin = 0;
    logic [9:0] e;
    int unsigned n, o, d;
    trace.delete();
    while (!fin) begin
      e = rom[song][p];
      n = 32'(e[9:6]); o = 32'(e[5:4]); d = 32'(e[3:0]);
      add_slot(PH_FETCH, 0, 0, p);
      add_slot(PH_WAIT, 0, 0, p);
      if (n == 15) begin
        fin = 1;
      end else begin
        if (d != 0) begin
          for (int unsigned k = 0; k < d * TD - GAP; k++) add_slot(PH_PLAY, n, o, p);
          for (int unsigned k = 0; k < GAP; k++) add_slot(PH_GAP, 0, 0, p);
        end
        if (p == SL - 1) fin = 1;
        else p++;
      end
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_idx = 0; m_song = 1; m_done = 0;
    m_sel_q = 2'b00; m_pp_q = 1'b0;
    trace.delete();
  endtask

  task automatic model_step();
    logic [1:0] rs;
    logic rp;
    rs = song_select & ~m_sel_q;
    rp = play_pause & ~m_pp_q;
    m_sel_q = song_select;
    m_pp_q  = play_pause;
    m_done  = 0;
    if (rs != 2'b00) begin
      if (rs[0]) m_song = (m_song == NS) ? 1 : m_song + 1;
      else       m_song = (m_song == 1) ? NS : m_song - 1;
      build_trace(m_song);
      m_idx = 0;
    end else if (rp && m_mode == M_IDLE) begin
      build_trace(m_song);
      m_idx  = 0;
      m_mode = M_RUN;
    end else if (rp && m_mode == M_PAUSE) begin
      m_mode = M_RUN;
    end else if (rp && m_mode == M_RUN && trace[m_idx].ph inside {PH_PLAY, PH_GAP}) begin
      m_mode = M_PAUSE;
    end else if (m_mode == M_RUN) begin
      m_idx++;
      if (m_idx == trace.size()) begin
        m_idx = 0;
        if (!loop_en) begin
          m_mode = M_IDLE;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    int unsigned en = 0, eo = 0, ep = 0;
    if (m_mode == M_RUN) begin
      ep = 1;
      if (trace[m_idx].ph == PH_PLAY) begin
        en = trace[m_idx].note;
        eo = trace[m_idx].oct;
      end
      if (trace[m_idx].ph == PH_FETCH) check("rom_pos", 32'(rom_pos), trace[m_idx].pos);
    end
    check("note", 32'(note_to_play), en);
    check("octave", 32'(octave_auto), eo);
    check("led", 32'(led_out), exp_led(en));
    check("playing", 32'(playing), ep);
    check("song_done", 32'(song_done), 32'(m_done));
    check("song_num", 32'(song_num), m_song);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic reset_assert();
    reset = 1'b1;
    #1;
    check("rst_note", 32'(note_to_play), 0);
    check("rst_octave", 32'(octave_auto), 0);
    check("rst_led", 32'(led_out), 0);
    check("rst_playing", 32'(playing), 0);
    check("rst_done", 32'(song_done), 0);
    check("rst_song", 32'(song_num), 1);
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic press();
    play_pause = 1'b1; step();
    play_pause = 1'b0; step();
  endtask

  task automatic pulse_sel(input logic [1:0] v);
    song_select = v; step();
    song_select = 2'b00; step();
  endtask

  int unsigned exp_next [6] = '{2, 3, 4, 5, 6, 1};

  initial begin
    int first, nc, dc, zc, wraps, first_led;
    bit saw6;
    logic [2:0] prev_pos;

    for (int s = 0; s < 8; s++)
      for (int p = 0; p < 8; p++) rom[s][p] = ent(15, 0, 0);
    rom[1][0] = ent(3, 1, 2);
    for (int p = 0; p < 8; p++) rom[2][p] = ent((p % 7) + 1, p % 4, 1);
    rom[3][0] = ent(5, 2, 3);
    rom[4][0] = ent(6, 1, 0);
    rom[4][1] = ent(5, 1, 2);

    #2;
    reset_assert();
    reset_release();

    // Single note then END, stop mode
    loop_en = 1'b0;
    play_pause = 1'b1; step(); play_pause = 1'b0;
    first = -1; nc = 0; dc = 0; first_led = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (note_to_play == 4'd3) begin
        if (first < 0) begin first = i; first_led = 32'(led_out); end
        nc++;
      end
      if (song_done) dc++;
    end
    check("t1_first_note_cycle", 32'(first), 2);
    check("t1_led", 32'(first_led), 32'h04);
    check("t1_note_cycles", 32'(nc), 7);
    check("t1_done_pulses", 32'(dc), 1);
    check("t1_playing_end", 32'(playing), 0);

    // Loop mode over a full-length song
    loop_en = 1'b1;
    pulse_sel(2'b01);
    press();
    dc = 0; zc = 0; wraps = 0; prev_pos = rom_pos;
    for (int i = 0; i < 120; i++) begin
      step();
      if (song_done) dc++;
      if (!playing) zc++;
      if (prev_pos == 3'd7 && rom_pos == 3'd0) wraps++;
      prev_pos = rom_pos;
    end
    check("t2_done_pulses", 32'(dc), 0);
    check("t2_playing_drops", 32'(zc), 0);
    check("t2_wrapped", 32'(wraps >= 1), 1);

    // Song selection wrap-around
    loop_en = 1'b0;
    reset_assert(); reset_release();
    for (int k = 0; k < 6; k++) begin
      pulse_sel(2'b01);
      check("t3_next", 32'(song_num), exp_next[k]);
    end
    pulse_sel(2'b10);
    check("t3_prev_wrap", 32'(song_num), 6);
    pulse_sel(2'b11);
    check("t3_both_next_wins", 32'(song_num), 1);

    // Pause with 3 ticks of the note remaining
    reset_assert(); reset_release();
    pulse_sel(2'b01); pulse_sel(2'b01);
    play_pause = 1'b1; step(); play_pause = 1'b0;
    for (int i = 1; i <= 10; i++) step();
    play_pause = 1'b1; step(); play_pause = 1'b0;
    zc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (note_to_play == 4'd0 && led_out == 7'd0) zc++;
    end
    check("t4_paused_rest", 32'(zc), 20);
    play_pause = 1'b1; step(); play_pause = 1'b0;
    nc = (note_to_play == 4'd5) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (note_to_play == 4'd5) nc++;
    end
    check("t4_resumed_cycles", 32'(nc), 3);

    // Skipped zero-duration entry, then asynchronous reset mid-note
    reset_assert(); reset_release();
    pulse_sel(2'b01); pulse_sel(2'b01); pulse_sel(2'b01);
    play_pause = 1'b1; step(); play_pause = 1'b0;
    first = -1; saw6 = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (note_to_play == 4'd5 && first < 0) first = i;
      if (note_to_play == 4'd6) saw6 = 1;
    end
    check("t5_first_note_cycle", 32'(first), 4);
    check("t5_skipped_never_shown", 32'(saw6), 0);
    check("t5_mid_note_before_reset", 32'(note_to_play), 5);
    reset_assert();
    reset_release();
    for (int i = 0; i < 5; i++) step();

    // Random button activity over random songs
    for (int r = 0; r < 4; r++) begin
      for (int s = 1; s <= 6; s++)
        for (int p = 0; p < 8; p++)
          rom[s][p] = ent(($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 14),
                          $urandom_range(0, 3), $urandom_range(0, 3));
      play_pause  = 1'($urandom_range(0, 1));
      song_select = 2'b00;
      loop_en     = 1'($urandom_range(0, 1));
      reset_assert();
      reset_release();
      for (int i = 0; i < 700; i++) begin
        step();
        if ($urandom_range(0, 24) == 0)  play_pause = ~play_pause;
        if ($urandom_range(0, 149) == 0) song_select[0] = ~song_select[0];
        if ($urandom_range(0, 149) == 0) song_select[1] = ~song_select[1];
        if ($urandom_range(0, 99) == 0)  loop_en = ~loop_en;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Parametrised successor to the auto-play song block.
- Steps through a song held in an external synchronous note ROM (note, octave and duration per entry) and drives the buzzer note, the octave and a one-hot LED bar.
- Adds several features the previous block lacks: play/pause, loop or stop-at-end mode, an end-of-song pulse, a programmable inter-note articulation gap, and generic song count, song length and field widths.
- Sits between the user button debouncers and the buzzer/LED drivers in auto mode.

Parameters:
- TICK_DIV, 10000000: clock cycles per duration unit.
- SONG_LEN, 56: maximum entries per song; position wraps after SONG_LEN-1.
- NUM_SONGS, 6: number of selectable songs, numbered 1..NUM_SONGS.
- NOTE_W, 4: note code width.
- OCT_W, 2: octave field width.
- DUR_W, 4: duration field width, in tick units.
- END_CODE, 4'hF: note code marking end of song.
- GAP_CYCLES, 0: rest cycles inserted at the tail of each note; must be less than TICK_DIV.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- song_select, in, 2: [0] next song, [1] previous song; level inputs, rising-edge detected internally.
- play_pause, in, 1: level input; a rising edge toggles play/pause.
- loop_en, in, 1: 1 = restart at position 0 on song end; 0 = stop on song end.
- rom_song, out, $clog2(NUM_SONGS+1): song number presented to the ROM.
- rom_pos, out, $clog2(SONG_LEN): entry index presented to the ROM.
- rom_data, in, NOTE_W+OCT_W+DUR_W: {note, octave, duration}; valid exactly 1 cycle after rom_song/rom_pos.
- note_to_play, out, NOTE_W: note sent to the buzzer; 0 = rest.
- octave_auto, out, OCT_W: octave of the current note.
- led_out, out, 7: one-hot LED; note k (1..7) lights bit k-1; any other code gives all zeros.
- song_num, out, $clog2(NUM_SONGS+1): currently selected song.
- playing, out, 1: high in FETCH, WAIT, PLAY and GAP.
- song_done, out, 1: one-cycle pulse when a song ends with loop_en=0.

Behaviour:
- Reset:
  - State goes to IDLE; song_num=1, position=0.
  - note_to_play, octave_auto, led_out, playing and song_done are all 0.
  - Edge-detect history registers clear to 0, so an input already high when reset releases counts as a rising edge.
- States: IDLE, FETCH, WAIT, PLAY, GAP, PAUSE.
- FETCH:
  - rom_song/rom_pos driven with the current song and position.
  - Always moves to WAIT on the next cycle.
- WAIT: rom_data is sampled.
  - note == END_CODE, or position wrap: treated as end of song.
    - loop_en=1: position=0, go to FETCH.
    - loop_en=0: pulse song_done, playing=0, position=0, outputs go to rest, go to IDLE.
  - duration == 0: entry skipped; position+1, go to FETCH.
  - Otherwise: latch note/octave, register note_to_play and led_out, load unit counter = duration, clear tick counter, go to PLAY.
  - Note appears at the outputs 2 cycles after FETCH entry.
- PLAY:
  - Tick counter counts 0..TICK_DIV-1; each wrap decrements the unit counter.
  - When the unit counter is 1 and tick = TICK_DIV-1-GAP_CYCLES, go to GAP (when GAP_CYCLES=0, go straight to the advance step).
- GAP:
  - Outputs forced to rest (note 0, LEDs 0) for GAP_CYCLES cycles.
  - Then advance position: position+1, or treated as end of song when position == SONG_LEN-1. Go to FETCH.
- play_pause rising edge:
  - IDLE → FETCH; playing=1.
  - PLAY or GAP → PAUSE: counters frozen, outputs forced to rest.
  - PAUSE → resumes the saved state with its counters; the note is restored.
  - Ignored while in FETCH or WAIT; the press is not queued.
- Song selection (rising edges):
  - Next song: song_num+1, wrapping NUM_SONGS → 1.
  - Previous song: song_num-1, wrapping 1 → NUM_SONGS.
  - Both edges in the same cycle: next wins.
  - On a change: position=0, counters cleared, outputs go to rest.
    - From PLAY, GAP, FETCH or WAIT: go to FETCH.
    - From IDLE or PAUSE: stay in that state (PAUSE resumes at the new song via FETCH).
- Priority in one cycle: reset > song change > play_pause > sequencing.
- Counter widths:
  - Tick counter: $clog2(TICK_DIV).
  - Unit counter: DUR_W.
  - No multiplier is used.

Test Plan (TICK_DIV=4, GAP_CYCLES=1, SONG_LEN=8):
1. Reset, then play_pause pulse; ROM song 1 = {note 3, oct 1, dur 2}, END → note_to_play=3 and led_out=0000100 exactly 2 cycles after FETCH; held for 7 cycles, then 1 rest cycle; song_done pulses 1 cycle after END is sampled with loop_en=0; playing=0.
2. loop_en=1, 8 non-END entries → after entry 7, rom_pos returns to 0 with no song_done pulse; playing stays 1.
3. song_select[0] pulsed 6 times from song 1 → song_num sequence 2,3,4,5,6,1; song_select[1] from 1 → 6; both rising in the same cycle → next wins.
4. play_pause mid-note with 3 ticks remaining → outputs 0 while paused for 20 cycles; after the second press the note resumes and lasts exactly 3 more cycles plus the gap.
5. Entry with dur=0 followed by note 5 → note 5 appears with no output cycle for the skipped entry; reset asserted mid-note → all outputs 0 immediately (asynchronous), song_num=1, state IDLE.
